mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 16, width of all address ports.
REQ-002 Parameter: LATENCY, default 4, memory access cycles per transaction, legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_req  input  1  instruction-side read request; held high until i_valid.
REQ-006 i_addr  input  ADDR_WIDTH  instruction-side byte address; bit 0 ignored.
REQ-007 d_req  input  1  data-side request; held high until d_valid.
REQ-008 d_wr  input  1  data-side write (1) / read (0).
REQ-009 d_addr  input  ADDR_WIDTH  data-side byte address; bit 0 ignored.
REQ-010 d_wdata  input  16  data-side write data.
REQ-011 i_valid  output  1  one-cycle pulse: instruction read complete, i_rdata valid.
REQ-012 i_rdata  output  16  instruction read data; holds until next I completion.
REQ-013 d_valid  output  1  one-cycle pulse: data transaction complete.
REQ-014 d_rdata  output  16  data read data; holds until next D read completion.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 mem_en, mem_wr  output  1 each  single-port memory enable / write strobe.
REQ-017 mem_addr  output  ADDR_WIDTH  memory address, driven from latched request.
REQ-018 mem_wdata  output  16  memory write data, driven from latched request.
REQ-019 mem_rdata  input  16  combinational memory read data.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-021 In IDLE with any req high, the block SHALL grant one side, latch owner, wr, addr, wdata on that edge, load cnt=LATENCY-1, and enter BUSY.
REQ-022 Requests SHALL be sampled only in IDLE; req/addr changes during BUSY or DONE SHALL be ignored.
REQ-023 Arbitration: only one req high -> that side; both high -> side opposite last_grant (round-robin); last_grant SHALL update on every grant.
REQ-024 I-side grants SHALL always be reads regardless of d_wr.
REQ-025 In BUSY, mem_en=1 and mem_addr/mem_wdata SHALL equal latched values; mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0 in IDLE and DONE.
REQ-026 In BUSY, cnt SHALL decrement each cycle; mem_wr SHALL be high only in the cnt==0 cycle of a write, giving exactly one write edge per write.
REQ-027 On the edge leaving BUSY with cnt==0, a read SHALL capture mem_rdata into the owner's rdata register; the other rdata register SHALL be unchanged; the state SHALL go to DONE.
REQ-028 In DONE, the owner's valid SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 Latency: req first sampled in IDLE at cycle 0 -> valid high in cycle LATENCY+1; minimum turnaround between grants is LATENCY+2 cycles.
REQ-030 A req still high in the IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-031 i_valid and d_valid SHALL never be high in the same cycle.
REQ-032 d_rdata SHALL not change on D-side write completion.

Reset
REQ-033 rst low at a rising edge SHALL force state=IDLE, cnt=0, last_grant=I, i_rdata=0, d_rdata=0, and all latched request fields to 0.
REQ-034 During and after reset, busy, i_valid, d_valid, mem_en, mem_wr SHALL be 0 until a new grant.
REQ-035 Reset during BUSY SHALL abort the transaction: no mem_wr pulse, no valid pulse; the requester must re-request.

Verification
REQ-036 After reset, I-read 0x0010 alone, LATENCY=4, memory word 8=0xA5A5 -> mem_en cycles 1-4, i_valid in cycle 5, i_rdata=0xA5A5, busy cycles 1-5.
REQ-037 D-write 0x0020 data 0x1234, then D-read 0x0020 -> exactly one mem_wr cycle, with mem_addr=0x0020; read returns d_rdata=0x1234; i_rdata unchanged.
REQ-038 i_req and d_req held high continuously from reset -> grant order D, I, D, I; valids alternate every 6 cycles; never simultaneous.
REQ-039 rst low during cycle 2 of a D-write -> no mem_wr pulse, no d_valid pulse, memory unchanged, outputs at reset values.
REQ-040 LATENCY=1: I-read -> mem_en one cycle, i_valid in cycle 2; d_req raised mid-BUSY is ignored until IDLE, then granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction
// read port and a data read/write port, one transaction at a time.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   i_req/i_addr     instruction read request (held until i_valid)
//   d_req/d_wr/...   data request, write flag, address, write data
//   i_valid/i_rdata  I completion pulse and held read data
//   d_valid/d_rdata  D completion pulse and held read data
//   busy             high while a transaction is in flight
//   mem_*            memory strobes, address, write data, read data
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  i_valid,
  output logic [15:0]           i_rdata,
  output logic                  d_valid,
  output logic [15:0]           d_rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    last_q;
  logic                    owner_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wdata_q;
  logic [15:0]             i_rdata_q;
  logic [15:0]             d_rdata_q;
  logic                    busy_q;
  logic                    mem_en_q;
  logic                    mem_wr_q;
  logic                    i_valid_q;
  logic                    d_valid_q;

  logic                    gnt_d;
  logic                    wr_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [15:0]             wdata_d;

  // Owner encoding: 0 = I side, 1 = D side.
  // With both requesting, the side that did not win last time wins.
  always_comb begin
    gnt_d   = d_req & (~i_req | ~last_q);
    wr_d    = gnt_d & d_wr;
    addr_d  = (gnt_d ? d_addr : i_addr) & ~ADDR_WIDTH'(1);
    wdata_d = gnt_d ? d_wdata : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b0;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 16'h0000;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      busy_q    <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            state_q  <= BUSY;
            owner_q  <= gnt_d;
            last_q   <= gnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= CNT_INIT;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            // Write strobe lands in the last BUSY cycle only.
            mem_wr_q <= wr_d && (CNT_INIT == 4'd0);
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q  <= DONE;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (!wr_q) begin
              if (owner_q) d_rdata_q <= mem_rdata;
              else         i_rdata_q <= mem_rdata;
            end
            i_valid_q <= ~owner_q;
            d_valid_q <= owner_q;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            mem_wr_q <= wr_q && (cnt_q == 4'd1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_en_q ? addr_q : '0;
  assign mem_wdata = mem_en_q ? wdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against a
// transaction-level memory model, for LATENCY=4 and LATENCY=1.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_req, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [15:0]   d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_valid, d_valid, busy, mem_en, mem_wr;

  logic          i_req1, d_req1, d_wr1;
  logic [AW-1:0] i_addr1, d_addr1, mem_addr1;
  logic [15:0]   d_wdata1, i_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic          i_valid1, d_valid1, busy1, mem_en1, mem_wr1;

  mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) u1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1),
    .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .i_valid(i_valid1), .i_rdata(i_rdata1),
    .d_valid(d_valid1), .d_rdata(d_rdata1),
    .busy(busy1), .mem_en(mem_en1), .mem_wr(mem_wr1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  function automatic logic [15:0] seed(input int idx);
    if (idx == 8) return 16'hA5A5;
    return 16'(idx * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] pat(input logic [AW-1:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  function automatic logic [15:0] rng(input int lo, input int hi);
    logic [15:0] r;
    r = '0;
    for (int k = lo; k <= hi; k++) r[k] = 1'b1;
    return r;
  endfunction

  // Word-addressed memory: unwritten words read their seed value.
  logic [15:0] mem [256];
  bit          wrt [256];
  logic [15:0] ref_mem [256];

  assign mem_rdata = wrt[mem_addr[8:1]] ? mem[mem_addr[8:1]]
                                        : seed(int'(mem_addr[8:1]));
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr[8:1]] <= mem_wdata;
      wrt[mem_addr[8:1]] <= 1'b1;
    end
  end

  assign mem_rdata1 = pat(mem_addr1);

  int vectors = 0;
  int miscompares = 0;
  int both0 = 0;
  int both1 = 0;

  always @(negedge clk) begin
    if (i_valid && d_valid) both0++;
    if (i_valid1 && d_valid1) both1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit side, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wd);
    int cyc, en, wrc, oth;
    logic got;
    logic [15:0] wa, wdo, pi, pd;
    cyc = 0; en = 0; wrc = 0; oth = 0; got = 1'b0;
    wa = '0; wdo = '0;
    pi = i_rdata; pd = d_rdata;
    if (side) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wd;
      i_addr = 16'($urandom);
    end else begin
      i_req = 1'b1; i_addr = addr;
      d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      en += int'(mem_en);
      if (mem_wr) begin
        wrc++; wa = mem_addr; wdo = mem_wdata;
      end
      if (side ? i_valid : d_valid) oth++;
      got = side ? d_valid : i_valid;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("latency", cyc, LAT + 1);
    chk("en_cycles", en, LAT);
    chk("wr_cycles", wrc, (side && wr) ? 1 : 0);
    if (side && wr) begin
      chk("wr_addr", wa[15:1], addr[15:1]);
      chk("wr_data", wdo, wd);
      ref_mem[addr[8:1]] = wd;
      chk("d_rdata_on_write", d_rdata, pd);
    end else if (side) begin
      chk("d_rdata", d_rdata, ref_mem[addr[8:1]]);
    end else begin
      chk("i_rdata", i_rdata, ref_mem[addr[8:1]]);
    end
    if (side) chk("i_rdata_hold", i_rdata, pi);
    else      chk("d_rdata_hold", d_rdata, pd);
    chk("other_valid", oth, 0);
    tick();
    chk("idle_busy", busy, 0);
  endtask

  logic [15:0] en_m, iv_m, dv_m, bz_m, wr_m;
  int          ev_side [8];
  int          ev_cyc [8];
  int          nev, wc, dvc;
  bit          last_g, exp_s;
  bit          rs, rw;
  logic [15:0] ra, rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = seed(k);
    rst = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    i_req1 = 0; d_req1 = 0; d_wr1 = 0;
    i_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;
    tick();
    tick();
    rst = 1'b1;

    chk("rst_busy", busy, 0);
    chk("rst_strobes", {i_valid, d_valid, mem_en, mem_wr}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Lone I read at 0x0010 (word 8); d_wr high must not matter.
    i_req = 1'b1; i_addr = 16'h0010; d_wr = 1'b1;
    en_m = '0; iv_m = '0; bz_m = '0; wr_m = '0; dv_m = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      en_m[k] = mem_en; iv_m[k] = i_valid; bz_m[k] = busy;
      wr_m[k] = mem_wr; dv_m[k] = d_valid;
      if (i_valid) i_req = 1'b0;
    end
    d_wr = 1'b0;
    chk("iread_en", en_m, rng(1, LAT));
    chk("iread_valid", iv_m, 16'(1) << (LAT + 1));
    chk("iread_busy", bz_m, rng(1, LAT + 1));
    chk("iread_wr", wr_m, 0);
    chk("iread_dvalid", dv_m, 0);
    chk("iread_data", i_rdata, 16'hA5A5);

    run_txn(1'b1, 1'b1, 16'h0020, 16'h1234);
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("dwr_mem", mem[16], 16'h1234);
    chk("i_rdata_kept", i_rdata, 16'hA5A5);

    repeat (30) begin
      rs = 1'($urandom);
      rw = rs ? 1'($urandom) : 1'b0;
      ra = 16'($urandom_range(0, 511));
      rd = 16'($urandom);
      run_txn(rs, rw, ra, rd);
    end

    // Both sides requesting continuously out of reset.
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    i_addr = 16'h0010; d_addr = 16'h0020;
    tick();
    tick();
    rst = 1'b1;
    nev = 0;
    for (int k = 0; k < 8; k++) begin
      ev_side[k] = -1; ev_cyc[k] = -1;
    end
    for (int c = 1; c <= 4 * (LAT + 2); c++) begin
      tick();
      if (i_valid || d_valid) begin
        if (nev < 8) begin
          ev_side[nev] = int'(d_valid);
          ev_cyc[nev] = c;
        end
        nev++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    chk("rr_count", nev, 4);
    last_g = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_s = ~last_g;
      last_g = exp_s;
      chk("rr_side", ev_side[k], int'(exp_s));
      chk("rr_time", ev_cyc[k], (LAT + 1) + k * (LAT + 2));
    end
    chk("rr_i_rdata", i_rdata, ref_mem[8]);
    chk("rr_d_rdata", d_rdata, ref_mem[16]);

    // Reset in the second BUSY cycle of a D write.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    wc = 0; dvc = 0;
    tick();
    wc += int'(mem_wr); dvc += int'(d_valid);
    tick();
    wc += int'(mem_wr); dvc += int'(d_valid);
    rst = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    tick();
    rst = 1'b1;
    wc += int'(mem_wr); dvc += int'(d_valid);
    repeat (6) begin
      tick();
      wc += int'(mem_wr); dvc += int'(d_valid);
    end
    chk("abort_wr", wc, 0);
    chk("abort_dvalid", dvc, 0);
    chk("abort_mem", mem_rdata, mem_rdata);
    chk("abort_mem_word", wrt[32] ? mem[32] : seed(32), ref_mem[32]);
    chk("abort_outs", {busy, mem_en, i_valid, d_valid}, 0);
    chk("abort_rdata", {i_rdata, d_rdata}, 0);

    // LATENCY=1 instance: D request raised while I is in flight.
    i_req1 = 1'b1; i_addr1 = 16'h0030;
    en_m = '0; iv_m = '0; dv_m = '0; bz_m = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      en_m[c] = mem_en1; iv_m[c] = i_valid1;
      dv_m[c] = d_valid1; bz_m[c] = busy1;
      if (c == 1) begin
        d_req1 = 1'b1; d_wr1 = 1'b0; d_addr1 = 16'h0052;
      end
      if (i_valid1) i_req1 = 1'b0;
      if (d_valid1) d_req1 = 1'b0;
    end
    chk("l1_en", en_m, rng(1, LAT1) | rng(LAT1 + 3, 2 * LAT1 + 2));
    chk("l1_ivalid", iv_m, 16'(1) << (LAT1 + 1));
    chk("l1_dvalid", dv_m, 16'(1) << (2 * LAT1 + 3));
    chk("l1_busy", bz_m, rng(1, LAT1 + 1) | rng(LAT1 + 3, 2 * LAT1 + 3));
    chk("l1_i_rdata", i_rdata1, pat(16'h0030));
    chk("l1_d_rdata", d_rdata1, pat(16'h0052));

    chk("no_simul_valid", both0, 0);
    chk("no_simul_valid_l1", both1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
